// File: rtl/shape_cmd_pkg.sv
// Shared definitions for the shape command processor: SFR map, STATUS layout
// and engine state encoding.
package shape_cmd_pkg;

  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_STATUS     = 2'd1;
  localparam logic [1:0] ADDR_DONE_COUNT = 2'd2;

  localparam int STAT_ERR_SHAPE = 0;
  localparam int STAT_ERR_OVF   = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } eng_state_t;

endpackage

// File: rtl/shape_cmd_if.sv
// Register-bus interface between a host (master) and the shape command
// processor (slave).
interface shape_cmd_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  write;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output write, addr, write_data, read,
    input  read_data
  );

  modport slave (
    input  write, addr, write_data, read,
    output read_data
  );

endinterface

// File: rtl/shape_cmd_fifo.sv
// Circular-buffer command FIFO with an explicit 0..DEPTH occupancy counter.
module shape_cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/shape_cmd_processor.sv
// Bus-slave shape command processor: validates CTRL writes, queues legal
// commands and executes them one by one for operation+1 cycles each.
module shape_cmd_processor
  import shape_cmd_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAPE_WIDTH = 2,
  parameter int OP_WIDTH    = 5,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  shape_cmd_if.slave     bus,
  output logic           error,
  output logic           busy,
  output logic           done
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CMD_W = SHAPE_WIDTH + OP_WIDTH;

  typedef struct packed {
    logic [SHAPE_WIDTH-1:0] shape;
    logic [OP_WIDTH-1:0]    operation;
  } shape_cmd_t;

  shape_cmd_t            wr_cmd;
  shape_cmd_t            ctrl_q;
  shape_cmd_t            head_cmd;
  logic                  shape_ok;
  logic                  ctrl_wr;
  logic                  status_wr;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [LVL_W-1:0]      level;
  logic                  set_shape;
  logic                  set_ovf;
  logic                  err_shape;
  logic                  err_ovf;
  eng_state_t            state_q;
  eng_state_t            state_d;
  logic [OP_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]  done_cnt;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_bits;

  assign wr_cmd.shape     = bus.write_data[16 +: SHAPE_WIDTH];
  assign wr_cmd.operation = bus.write_data[0 +: OP_WIDTH];
  assign shape_ok         = $onehot(wr_cmd.shape);
  assign ctrl_wr          = bus.write && (bus.addr == ADDR_CTRL);
  assign status_wr        = bus.write && (bus.addr == ADDR_STATUS);

  // Shape legality is judged first; a full FIFO only matters for legal commands.
  assign push      = ctrl_wr && shape_ok && !full;
  assign set_shape = ctrl_wr && !shape_ok;
  assign set_ovf   = ctrl_wr && shape_ok && full;

  assign unused_bits = ^{bus.write_data, head_cmd.shape};

  shape_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (push) begin
      ctrl_q <= wr_cmd;
    end
  end

  // Sticky causes: a same-cycle set beats the write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_shape <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_shape <= set_shape || (err_shape && !(status_wr && bus.write_data[STAT_ERR_SHAPE]));
      err_ovf   <= set_ovf   || (err_ovf   && !(status_wr && bus.write_data[STAT_ERR_OVF]));
    end
  end

  assign error = err_shape | err_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!empty) state_d = ST_EXEC;
      ST_EXEC: if ((cnt_q == '0) && empty) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_IDLE: pop = !empty;
      ST_EXEC: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          pop  = !empty;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == ST_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= head_cmd.operation;
    end else if (busy) begin
      cnt_q <= cnt_q - OP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    done_cnt <= '0;
    else if (done) done_cnt <= done_cnt + CNT_WIDTH'(1);
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        rd_val[16 +: SHAPE_WIDTH] = ctrl_q.shape;
        rd_val[0 +: OP_WIDTH]     = ctrl_q.operation;
      end
      ADDR_STATUS: begin
        rd_val[STAT_ERR_SHAPE]          = err_shape;
        rd_val[STAT_ERR_OVF]            = err_ovf;
        rd_val[STAT_BUSY]               = busy;
        rd_val[STAT_LEVEL_LSB +: LVL_W] = level;
      end
      ADDR_DONE_COUNT: rd_val[CNT_WIDTH-1:0] = done_cnt;
      default: rd_val = '0;
    endcase
  end

  // Sampled from current register state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bus.read_data <= '0;
    else if (bus.read) bus.read_data <= rd_val;
  end

endmodule

// File: tb/tb_shape_cmd_processor.sv
// Bench for shape_cmd_processor: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_shape_cmd_processor;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic error, busy, done;

  shape_cmd_if #(.DATA_WIDTH(DW)) bus ();

  shape_cmd_processor #(
    .DATA_WIDTH (DW),
    .SHAPE_WIDTH(2),
    .OP_WIDTH   (5),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .error (error),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pending operations, remaining cycles of the active one.
  int          m_q[$];
  bit          m_busy;
  int          m_rem;
  int          m_cnt;
  bit          m_es, m_eo;
  int          m_shape, m_op;
  logic [31:0] m_rd;

  function automatic void m_reset();
    m_q.delete();
    m_busy = 0; m_rem = 0; m_cnt = 0;
    m_es = 0; m_eo = 0; m_shape = 0; m_op = 0; m_rd = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (32'(m_shape) << 16) | 32'(m_op);
      2'd1:    return 32'(m_es) | (32'(m_eo) << 1) | (32'(m_busy) << 2) | (32'(m_q.size()) << 8);
      2'd2:    return 32'(m_cnt);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_step(input bit w, input logic [1:0] a, input logic [31:0] wd, input bit r);
    int  sz;
    int  shp;
    bit  set_s, set_o;
    if (r) m_rd = m_read(a);
    sz = m_q.size();
    if (m_busy && m_rem == 1) m_cnt = (m_cnt + 1) % 65536;
    if (!m_busy || m_rem == 1) begin
      if (sz > 0) begin
        m_rem  = m_q.pop_front() + 1;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_rem--;
    end
    set_s = 0; set_o = 0;
    shp = int'(wd[17:16]);
    if (w && a == 2'd0) begin
      if (shp != 1 && shp != 2) set_s = 1;
      else if (sz == DEPTH)     set_o = 1;
      else begin
        m_q.push_back(int'(wd[4:0]));
        m_shape = shp;
        m_op    = int'(wd[4:0]);
      end
    end
    m_es = set_s || (m_es && !(w && a == 2'd1 && wd[0]));
    m_eo = set_o || (m_eo && !(w && a == 2'd1 && wd[1]));
  endfunction

  task automatic tick(input bit w, input logic [1:0] a, input logic [31:0] wd, input bit r);
    bus.write = w; bus.addr = a; bus.write_data = wd; bus.read = r;
    @(posedge clk);
    m_step(w, a, wd, r);
    #1;
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

  task automatic do_reset();
    bus.write = 1'b0; bus.read = 1'b0; bus.addr = 2'd0; bus.write_data = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick(1, 2'd0, 32'h0000_0003, 0);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(0, 2'd1, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", bus.read_data); end
    tick(0, 2'd2, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL reset_donecnt: got %h want 0", bus.read_data); end
  endtask

  task automatic test_single_cmd();
    do_reset();
    tick(1, 2'd0, 32'h0001_0003, 0);
    for (int k = 1; k <= 5; k++) begin
      tick(0, 2'd0, 0, 0);
      n_tests++;
      if (busy !== 1'((k <= 4)) || done !== 1'((k == 4))) begin
        n_fail++; $display("FAIL single_cycle%0d: busy=%b done=%b want busy=%b done=%b", k, busy, done, (k <= 4), (k == 4));
      end
    end
    tick(0, 2'd2, 0, 1);
    n_tests++; if (bus.read_data !== 32'd1) begin n_fail++; $display("FAIL single_donecnt: got %h want 1", bus.read_data); end
    tick(0, 2'd0, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0001_0003) begin n_fail++; $display("FAIL single_ctrl: got %h want 00010003", bus.read_data); end
  endtask

  task automatic test_bad_shape();
    tick(1, 2'd0, 32'h0003_0001, 0);
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL badshape_error: got %b want 1", error); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badshape_busy: got %b want 0", busy); end
    tick(0, 2'd1, 0, 1);
    n_tests++; if (bus.read_data !== 32'h1) begin n_fail++; $display("FAIL badshape_status: got %h want 1", bus.read_data); end
    tick(0, 2'd0, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0001_0003) begin n_fail++; $display("FAIL badshape_ctrl: got %h want 00010003", bus.read_data); end
    tick(1, 2'd1, 32'h1, 0);
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL badshape_clear: got %b want 0", error); end
    tick(1, 2'd0, 32'h0000_0002, 0);
    tick(1, 2'd1, 32'h1, 0);
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL zeroshape_clear: got %b want 0", error); end
  endtask

  task automatic test_overflow();
    int pulses;
    int prev;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 2'd0, 32'h0002_0007, 0);
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", error); end
    tick(0, 2'd1, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0000_0406) begin n_fail++; $display("FAIL ovf_status: got %h want 00000406", bus.read_data); end
    pulses = 0; prev = 0;
    for (int k = 7; k <= 60; k++) begin
      tick(0, 2'd0, 0, 0);
      if (done === 1'b1) begin
        n_tests++;
        if (k != prev + 8) begin n_fail++; $display("FAIL ovf_spacing: pulse at cycle %0d want %0d", k, prev + 8); end
        prev = k; pulses++;
      end
    end
    n_tests++; if (pulses != 5) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 5", pulses); end
    tick(0, 2'd2, 0, 1);
    n_tests++; if (bus.read_data !== 32'd5) begin n_fail++; $display("FAIL ovf_donecnt: got %h want 5", bus.read_data); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 2'd0, 32'h0001_0007, 0);
    tick(0, 2'd0, 0, 0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: busy=%b done=%b want 0 0", busy, done); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(0, 2'd1, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %h want 0", bus.read_data); end
    tick(0, 2'd2, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_donecnt: got %h want 0", bus.read_data); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_rw_same_cycle();
    do_reset();
    tick(1, 2'd0, 32'h0001_0002, 0);
    tick(1, 2'd0, 32'h0002_0005, 1);
    n_tests++; if (bus.read_data !== 32'h0001_0002) begin n_fail++; $display("FAIL rw_old: got %h want 00010002", bus.read_data); end
    tick(0, 2'd0, 0, 1);
    n_tests++; if (bus.read_data !== 32'h0002_0005) begin n_fail++; $display("FAIL rw_new: got %h want 00020005", bus.read_data); end
  endtask

  task automatic test_random();
    bit          w, r;
    logic [1:0]  a;
    logic [31:0] wd;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      w  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      wd = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 6));
      if (a == 2'd1) wd = 32'($urandom_range(0, 3));
      tick(w, a, wd, r);
      n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_busy); end
      n_tests++; if (done !== (m_busy && m_rem == 1)) begin n_fail++; $display("FAIL rand_done c%0d: got %b want %b", c, done, (m_busy && m_rem == 1)); end
      n_tests++; if (error !== (m_es | m_eo)) begin n_fail++; $display("FAIL rand_error c%0d: got %b want %b", c, error, (m_es | m_eo)); end
      n_tests++; if (bus.read_data !== m_rd) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h want %h", c, bus.read_data, m_rd); end
    end
  endtask

  initial begin
    bus.write = 1'b0; bus.read = 1'b0; bus.addr = 2'd0; bus.write_data = '0;
    m_reset();
    #3;
    test_reset();
    test_single_cmd();
    test_bad_shape();
    test_overflow();
    test_reset_mid_exec();
    test_rw_same_cycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
